simple_req_ack_arb: RTL and testbench



---
 rtl/simple_req_ack_pkg.sv | 32 +++
 rtl/simple_req_ack_rr_pick.sv | 44 ++++
 rtl/simple_req_ack_arb.sv | 184 ++++++++++++++++++
 tb/tb_simple_req_ack_arb.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_req_ack_pkg.sv
// ----------------------------------------------------------------------------
// simple_req_ack_pkg
// Shared types and constants for the multi-channel req/ack arbiter.
//   arb_state_t : arbiter FSM state encoding (IDLE, REQ, HOLD, REL)
//   ERR_CNT_W   : width of the saturating timeout counter
//   arb_dbg_t   : debug view of FSM state, round-robin pointer and grant
//   sat_inc()   : saturating increment for the timeout counter
// ----------------------------------------------------------------------------
package simple_req_ack_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2,
      REL  = 2'd3
   } arb_state_t;

   localparam int ERR_CNT_W = 16;
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

   // Pointer and grant are zero-extended to 4 bits (up to 16 channels).
   typedef struct packed {
      arb_state_t state;
      logic [3:0] rr_ptr;
      logic [3:0] grant;
   } arb_dbg_t;

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (v == ERR_CNT_MAX) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/simple_req_ack_rr_pick.sv
// ----------------------------------------------------------------------------
// simple_req_ack_rr_pick
// Combinational round-robin picker: returns the first set request index at
// or after ptr, wrapping to the lowest set index when nothing at/after ptr.
//   req   : request vector, one bit per channel
//   ptr   : round-robin start position
//   valid : at least one request is set
//   idx   : chosen channel index
// ----------------------------------------------------------------------------
module simple_req_ack_rr_pick #(
   parameter int NUM_CH = 4,
   parameter int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [ID_W-1:0]   ptr,
   output logic              valid,
   output logic [ID_W-1:0]   idx
);

   logic            hi_found;
   logic [ID_W-1:0] hi_idx;
   logic [ID_W-1:0] lo_idx;

   // Descending scan: the last hit written is the lowest index, so hi_idx is
   // the lowest set index >= ptr and lo_idx the lowest set index overall.
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (req[i]) begin
            if (ID_W'(i) >= ptr) begin
               hi_found = 1'b1;
               hi_idx   = ID_W'(i);
            end
            lo_idx = ID_W'(i);
         end
      end
   end

   assign valid = |req;
   assign idx   = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/simple_req_ack_arb.sv
// ----------------------------------------------------------------------------
// simple_req_ack_arb
// Round-robin arbiter merging NUM_CH 4-phase req/ack requesters onto one
// downstream req/ack port, with a watchdog on the downstream ack edges.
//   clock, reset   : single clock, synchronous active-high reset
//   up_req/up_ack  : per-channel 4-phase handshake, up_data payload per channel
//   up_err         : valid with up_ack, 1 = transaction timed out
//   dn_req/dn_ack  : downstream 4-phase handshake, dn_data/dn_id of the grant
//   busy           : FSM not in IDLE
//   timeout_pulse  : one cycle per watchdog expiry
//   err_count      : saturating timeout count
//   dbg            : FSM state, round-robin pointer and current grant
//
// Handshake (4-phase, level based): a requester raises req with stable data,
// the responder raises ack, the requester drops req, the responder drops ack.
// No phase may be skipped; the arbiter forwards each phase of the granted
// channel and only returns to IDLE after the downstream ack has fallen (or
// the watchdog gave up on it).
// ----------------------------------------------------------------------------
module simple_req_ack_arb
   import simple_req_ack_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 256,
   parameter int ID_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        up_req,
   input  logic [NUM_CH*DATA_W-1:0] up_data,
   output logic [NUM_CH-1:0]        up_ack,
   output logic [NUM_CH-1:0]        up_err,
   output logic                     dn_req,
   output logic [DATA_W-1:0]        dn_data,
   output logic [ID_W-1:0]          dn_id,
   input  logic                     dn_ack,
   output logic                     busy,
   output logic                     timeout_pulse,
   output logic [ERR_CNT_W-1:0]     err_count,
   output arb_dbg_t                 dbg
);

   localparam int WDOG_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [WDOG_W-1:0] WDOG_LAST =
      (TIMEOUT_CYCLES > 0) ? WDOG_W'(TIMEOUT_CYCLES - 1) : '0;

   arb_state_t           state_q, state_d;
   logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]      grant_q, grant_d;
   logic [WDOG_W-1:0]    wdog_q, wdog_d, wdog_inc;
   logic                 wdog_hit;
   logic                 pick_valid;
   logic [ID_W-1:0]      pick_idx;
   logic [ID_W-1:0]      grant_next;
   logic                 req_g;

   logic [NUM_CH-1:0]    up_ack_d, up_err_d;
   logic                 dn_req_d, busy_d, pulse_d;
   logic [DATA_W-1:0]    dn_data_d;
   logic [ID_W-1:0]      dn_id_d;
   logic [ERR_CNT_W-1:0] err_count_d;

   simple_req_ack_rr_pick #(
      .NUM_CH (NUM_CH),
      .ID_W   (ID_W)
   ) u_pick (
      .req   (up_req),
      .ptr   (rr_ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // A zero timeout disables the watchdog: the counter stays parked at 0
   // and never reports expiry.
   assign wdog_hit   = (TIMEOUT_CYCLES != 0) && (wdog_q == WDOG_LAST);
   assign wdog_inc   = (TIMEOUT_CYCLES == 0) ? '0 : wdog_q + 1'b1;
   assign req_g      = up_req[grant_q];
   assign grant_next = (grant_q == ID_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;

   // State register, also holding every registered output.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         rr_ptr_q      <= '0;
         grant_q       <= '0;
         wdog_q        <= '0;
         up_ack        <= '0;
         up_err        <= '0;
         dn_req        <= 1'b0;
         dn_data       <= '0;
         dn_id         <= '0;
         busy          <= 1'b0;
         timeout_pulse <= 1'b0;
         err_count     <= '0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_q       <= grant_d;
         wdog_q        <= wdog_d;
         up_ack        <= up_ack_d;
         up_err        <= up_err_d;
         dn_req        <= dn_req_d;
         dn_data       <= dn_data_d;
         dn_id         <= dn_id_d;
         busy          <= busy_d;
         timeout_pulse <= pulse_d;
         err_count     <= err_count_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (pick_valid)         state_d = REQ;
         REQ:  if (dn_ack || wdog_hit) state_d = HOLD;
         HOLD: if (!req_g)             state_d = REL;
         REL:  if (!dn_ack || wdog_hit) state_d = IDLE;
         default:                      state_d = IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs. The watchdog
   // defaults to zero, which clears it on entry to REQ and REL.
   always_comb begin
      up_ack_d    = up_ack;
      up_err_d    = up_err;
      dn_req_d    = dn_req;
      dn_data_d   = dn_data;
      dn_id_d     = dn_id;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      pulse_d     = 1'b0;
      err_count_d = err_count;
      wdog_d      = '0;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               grant_d   = pick_idx;
               dn_id_d   = pick_idx;
               dn_data_d = up_data[pick_idx*DATA_W +: DATA_W];
               dn_req_d  = 1'b1;
            end
         end
         REQ: begin
            // A timed-out transaction still moves to HOLD with dn_req high;
            // a late dn_ack is simply not looked at there.
            if (dn_ack) begin
               up_ack_d[grant_q] = 1'b1;
               up_err_d[grant_q] = 1'b0;
            end else if (wdog_hit) begin
               up_ack_d[grant_q] = 1'b1;
               up_err_d[grant_q] = 1'b1;
               pulse_d           = 1'b1;
               err_count_d       = sat_inc(err_count);
            end else begin
               wdog_d = wdog_inc;
            end
         end
         HOLD: begin
            if (!req_g) dn_req_d = 1'b0;
         end
         REL: begin
            if (!dn_ack || wdog_hit) begin
               up_ack_d[grant_q] = 1'b0;
               up_err_d[grant_q] = 1'b0;
               rr_ptr_d          = grant_next;
               if (dn_ack) begin
                  pulse_d     = 1'b1;
                  err_count_d = sat_inc(err_count);
               end
            end else begin
               wdog_d = wdog_inc;
            end
         end
         default: ;
      endcase
      busy_d = (state_d != IDLE);
   end

   assign dbg = {state_q, 4'(rr_ptr_q), 4'(grant_q)};

endmodule

// File: tb/tb_simple_req_ack_arb.sv
// ----------------------------------------------------------------------------
// tb_simple_req_ack_arb
// Bench for simple_req_ack_arb: a 4-channel instance with an 8-cycle
// watchdog and a 1-channel instance with the watchdog disabled.
// ----------------------------------------------------------------------------
module tb_simple_req_ack_arb;
   import simple_req_ack_pkg::*;

   // ---------------- clock / reset ----------------
   logic clock;
   logic reset;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // ---------------- DUT: 4 channels, timeout 8 ----------------
   logic [3:0]   up_req;
   logic [127:0] up_data;
   logic [3:0]   up_ack, up_err;
   logic         dn_req, dn_ack, busy, timeout_pulse;
   logic [31:0]  dn_data;
   logic [1:0]   dn_id;
   logic [15:0]  err_count;
   arb_dbg_t     dbg;

   simple_req_ack_arb #(
      .NUM_CH(4), .DATA_W(32), .TIMEOUT_CYCLES(8)
   ) dut (
      .clock(clock), .reset(reset), .up_req(up_req), .up_data(up_data),
      .up_ack(up_ack), .up_err(up_err), .dn_req(dn_req), .dn_data(dn_data),
      .dn_id(dn_id), .dn_ack(dn_ack), .busy(busy),
      .timeout_pulse(timeout_pulse), .err_count(err_count), .dbg(dbg)
   );

   // ---------------- DUT0: 1 channel, watchdog disabled ----------------
   logic [0:0]  up_req0, up_ack0, up_err0, dn_id0;
   logic [31:0] up_data0, dn_data0;
   logic        dn_req0, dn_ack0, busy0, tp0;
   logic [15:0] ec0;
   arb_dbg_t    dbg0;

   simple_req_ack_arb #(
      .NUM_CH(1), .DATA_W(32), .TIMEOUT_CYCLES(0)
   ) dut0 (
      .clock(clock), .reset(reset), .up_req(up_req0), .up_data(up_data0),
      .up_ack(up_ack0), .up_err(up_err0), .dn_req(dn_req0), .dn_data(dn_data0),
      .dn_id(dn_id0), .dn_ack(dn_ack0), .busy(busy0),
      .timeout_pulse(tp0), .err_count(ec0), .dbg(dbg0)
   );

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;
   logic [33:0] exp_q[$];   // {expected dn_id, expected dn_data}

   typedef struct {
      logic [3:0] mask;
      int         ack_dly;
      logic [1:0] exp_id;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] chan_data(input logic [1:0] id);
      return 32'hA5A5_0000 + {30'd0, id};
   endfunction

   function automatic logic probe_ack();
      return |up_ack;
   endfunction

   // Bounded wait on |up_ack; an expired budget shows up as a failed check.
   task automatic wait_ack(input string name, input logic val, input int budget);
      int n;
      n = 0;
      while (probe_ack() !== val && n < budget) begin
         @(negedge clock);
         n++;
      end
      check(name, probe_ack(), val);
   endtask

   // ---------------- driver tasks ----------------
   // Full handshake on the 4-channel DUT; the granted channel drops its
   // request, the others keep the levels given in mask.
   task automatic run_txn(input logic [3:0] mask, input int ack_dly,
                          input logic [1:0] exp_id, input string tag);
      logic [33:0] exp;
      logic [1:0]  nxt;
      exp_q.push_back({exp_id, chan_data(exp_id)});
      up_req = mask;
      @(negedge clock);
      check({tag, "_dn_req"}, dn_req, 1'b1);
      exp = exp_q.pop_front();
      check({tag, "_dn_id"}, dn_id, exp[33:32]);
      check({tag, "_dn_data"}, dn_data, exp[31:0]);
      check({tag, "_busy"}, busy, 1'b1);
      repeat (ack_dly) @(negedge clock);
      dn_ack = 1'b1;
      @(negedge clock);
      check({tag, "_up_ack"}, up_ack, 4'b0001 << exp_id);
      check({tag, "_up_err"}, up_err, 4'b0000);
      up_req[exp_id] = 1'b0;
      @(negedge clock);
      check({tag, "_dn_req_rel"}, dn_req, 1'b0);
      dn_ack = 1'b0;
      @(negedge clock);
      nxt = exp_id + 2'd1;
      check({tag, "_up_ack_rel"}, up_ack, 4'b0000);
      check({tag, "_busy_end"}, busy, 1'b0);
      check({tag, "_rr_ptr"}, dbg.rr_ptr, {2'b00, nxt});
   endtask

   // REQ-side timeout followed by a clean release (dn_ack stays low).
   task automatic sat_txn(input logic [3:0] mask, input logic [15:0] exp_cnt, input string tag);
      up_req = mask;
      wait_ack({tag, "_ack_seen"}, 1'b1, 20);
      check({tag, "_up_err"}, up_err, mask);
      check({tag, "_pulse"}, timeout_pulse, 1'b1);
      check({tag, "_err_count"}, err_count, exp_cnt);
      up_req = 4'b0000;
      wait_ack({tag, "_ack_clr"}, 1'b0, 20);
      check({tag, "_err_count_hold"}, err_count, exp_cnt);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int pulses;
      int acks;

      // round-robin table, rr_ptr starts at 0
      vecs[0]  = '{4'b0100, 3, 2'd2};  // single channel, ack 3 cycles late
      vecs[1]  = '{4'b1010, 1, 2'd3};  // ptr=3, requests on 1 and 3
      vecs[2]  = '{4'b1010, 1, 2'd1};
      vecs[3]  = '{4'b1111, 1, 2'd2};
      vecs[4]  = '{4'b1111, 1, 2'd3};
      vecs[5]  = '{4'b1111, 1, 2'd0};  // all held: 0,1,2,3,0
      vecs[6]  = '{4'b1111, 1, 2'd1};
      vecs[7]  = '{4'b1111, 1, 2'd2};
      vecs[8]  = '{4'b1111, 1, 2'd3};
      vecs[9]  = '{4'b1111, 1, 2'd0};
      vecs[10] = '{4'b0001, 1, 2'd0};  // ptr=1, wrap to 0
      vecs[11] = '{4'b1000, 1, 2'd3};

      reset = 1'b1;
      up_req = '0;
      dn_ack = 1'b0;
      up_req0 = '0;
      dn_ack0 = 1'b0;
      up_data0 = 32'h5A5A_1234;
      for (int i = 0; i < 4; i++) up_data[i*32 +: 32] = chan_data(2'(i));
      repeat (3) @(negedge clock);
      reset = 1'b0;

      // reset values
      check("rst_up_ack", up_ack, 0);
      check("rst_up_err", up_err, 0);
      check("rst_dn_req", dn_req, 0);
      check("rst_dn_data", dn_data, 0);
      check("rst_dn_id", dn_id, 0);
      check("rst_busy", busy, 0);
      check("rst_pulse", timeout_pulse, 0);
      check("rst_err_count", err_count, 0);
      check("rst_dbg", dbg, 0);
      check("rst0_outs", {up_ack0, dn_req0, busy0, tp0, ec0}, 0);

      // table-driven grants
      for (int v = 0; v < 12; v++)
         run_txn(vecs[v].mask, vecs[v].ack_dly, vecs[v].exp_id, $sformatf("vec%0d", v));

      // timeout in REQ: ptr=0, channel 0, dn_ack never rises
      up_req = 4'b0001;
      @(negedge clock);
      check("to_req_dn_req", dn_req, 1'b1);
      check("to_req_dn_id", dn_id, 2'd0);
      for (int t = 1; t < 8; t++) begin
         @(negedge clock);
         check($sformatf("to_req_wait%0d", t), {up_ack, timeout_pulse}, 5'd0);
      end
      @(negedge clock);
      check("to_req_up_ack", up_ack, 4'b0001);
      check("to_req_up_err", up_err, 4'b0001);
      check("to_req_pulse", timeout_pulse, 1'b1);
      check("to_req_err_count", err_count, 16'd1);
      check("to_req_state", dbg.state, HOLD);
      // late dn_ack is ignored; dn_ack then stays high into REL
      dn_ack = 1'b1;
      @(negedge clock);
      check("to_late_pulse", timeout_pulse, 1'b0);
      check("to_late_up_err", up_err, 4'b0001);
      check("to_late_dn_req", dn_req, 1'b1);
      @(negedge clock);
      check("to_late_state", dbg.state, HOLD);

      // timeout in REL: dn_ack stuck high after up_req drops
      up_req = 4'b0000;
      @(negedge clock);
      check("to_rel_dn_req", dn_req, 1'b0);
      check("to_rel_state", dbg.state, REL);
      for (int t = 1; t < 8; t++) begin
         @(negedge clock);
         check($sformatf("to_rel_wait%0d", t), {up_ack, timeout_pulse}, {4'b0001, 1'b0});
      end
      @(negedge clock);
      check("to_rel_up_ack", up_ack, 4'b0000);
      check("to_rel_up_err", up_err, 4'b0000);
      check("to_rel_pulse", timeout_pulse, 1'b1);
      check("to_rel_err_count", err_count, 16'd2);
      check("to_rel_busy", busy, 1'b0);
      check("to_rel_rr_ptr", dbg.rr_ptr, 4'd1);
      dn_ack = 1'b0;
      @(negedge clock);
      check("to_rel_pulse_off", timeout_pulse, 1'b0);

      // reset in HOLD: protocol abort, bench drops its obligations
      up_req = 4'b0010;
      @(negedge clock);
      check("ab_dn_id", dn_id, 2'd1);
      dn_ack = 1'b1;
      @(negedge clock);
      check("ab_up_ack", up_ack, 4'b0010);
      check("ab_state", dbg.state, HOLD);
      reset = 1'b1;
      up_req = 4'b0000;
      dn_ack = 1'b0;
      exp_q.delete();
      @(negedge clock);
      check("ab_outs", {up_ack, up_err, dn_req, dn_id, busy, timeout_pulse}, 0);
      check("ab_dn_data", dn_data, 0);
      check("ab_err_count", err_count, 0);
      check("ab_dbg", dbg, 0);
      reset = 1'b0;
      run_txn(4'b0100, 1, 2'd2, "post_rst");

      // saturation: preload the counter one below the top
      force dut.err_count = 16'hFFFE;
      @(negedge clock);
      release dut.err_count;
      check("sat_preload", err_count, 16'hFFFE);
      sat_txn(4'b0001, 16'hFFFF, "sat1");
      sat_txn(4'b0001, 16'hFFFF, "sat2");

      // watchdog disabled, single channel: waits forever in REQ
      up_req0 = 1'b1;
      @(negedge clock);
      check("dis_dn_req", dn_req0, 1'b1);
      check("dis_dn_id", dn_id0, 1'b0);
      check("dis_dn_data", dn_data0, 32'h5A5A_1234);
      pulses = 0;
      acks = 0;
      for (int c = 0; c < 10000; c++) begin
         @(negedge clock);
         if (tp0) pulses++;
         if (up_ack0) acks++;
      end
      check("dis_pulses", pulses, 0);
      check("dis_acks", acks, 0);
      check("dis_state", dbg0.state, REQ);
      check("dis_err_count", ec0, 0);
      dn_ack0 = 1'b1;
      @(negedge clock);
      check("dis_up_ack", up_ack0, 1'b1);
      check("dis_up_err", up_err0, 1'b0);
      up_req0 = 1'b0;
      @(negedge clock);
      check("dis_dn_req_rel", dn_req0, 1'b0);
      dn_ack0 = 1'b0;
      @(negedge clock);
      check("dis_up_ack_rel", up_ack0, 1'b0);
      check("dis_busy", busy0, 1'b0);
      check("dis_rr_ptr", dbg0.rr_ptr, 4'd0);
      up_req0 = 1'b1;
      @(negedge clock);
      check("dis_regrant", {dn_req0, dn_id0}, 2'b10);

      check("final_q_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // global time limit
   initial begin
      #1_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "time limit");
   end

endmodule
